// File: rtl/wishbone_button_poller.sv
// ---------------------------------------------------------------------------
// wishbone_button_poller
//
// Wishbone classic initiator that periodically reads the button GPIO data
// register, debounces every returned bit on its own, and presents a stable
// button vector together with one-cycle press/release event pulses.
//
// Optional feature macro: WB_BTN_POLL_IRQ_EN
//   When defined, adds irq_o/irq_clr: a sticky interrupt flag that is set by
//   any press event and cleared by irq_clr (a set beats a clear in the same
//   cycle). When undefined, neither port nor any interrupt logic exists.
//
// Parameters:
//   BTN_ADDR     byte address of the button data register
//   NBTN         number of buttons, taken from dat_i[NBTN-1:0]
//   POLL_DIV     idle cycles between the end of one poll and the next (>=2)
//   DEBOUNCE_CNT consecutive identical reads needed to accept a bit (1..15)
//   ACK_TIMEOUT  bus cycles without ack_i before the read is abandoned (>=1)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   adr_o        Wishbone address (BTN_ADDR during a read, else 0)
//   dat_o        Wishbone write data, tied to 0
//   dat_i        Wishbone read data
//   we_o         write enable, tied to 0
//   sel_o        byte select (2'b11 during a read, else 0)
//   stb_o/cyc_o  strobe / cycle, registered
//   ack_i        responder acknowledge
//   poll_en      enables the poll divider
//   btn_state    debounced button levels
//   btn_press    one-cycle pulse on a debounced 0->1 transition
//   btn_release  one-cycle pulse on a debounced 1->0 transition
//   err_cnt      saturating count of timed-out reads
//   irq_o        (WB_BTN_POLL_IRQ_EN) sticky press interrupt
//   irq_clr      (WB_BTN_POLL_IRQ_EN) interrupt clear
// ---------------------------------------------------------------------------
module wishbone_button_poller #(
    parameter logic [31:0] BTN_ADDR     = 32'h0000_0000,
    parameter int          NBTN         = 4,
    parameter int          POLL_DIV     = 50000,
    parameter int          DEBOUNCE_CNT = 4,
    parameter int          ACK_TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic [31:0]     adr_o,
    output logic [31:0]     dat_o,
    input  logic [31:0]     dat_i,
    output logic            we_o,
    output logic [1:0]      sel_o,
    output logic            stb_o,
    output logic            cyc_o,
    input  logic            ack_i,
    input  logic            poll_en,
    output logic [NBTN-1:0] btn_state,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
`ifdef WB_BTN_POLL_IRQ_EN
    output logic            irq_o,
    input  logic            irq_clr,
`endif
    output logic [7:0]      err_cnt
);

    localparam int DIV_W = $clog2(POLL_DIV);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0]       DB_MAX   = 4'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        UPDATE
    } fsm_t;

    fsm_t                  fsm_q;
    logic [DIV_W-1:0]      div_q;
    logic [TMO_W-1:0]      tmo_q;
    logic [31:0]           adr_q;
    logic [1:0]            sel_q;
    logic                  cyc_q;
    logic                  stb_q;
    logic [7:0]            err_q;

    logic [NBTN-1:0]       sample_q;
    logic [NBTN-1:0]       cand_q;
    logic [NBTN-1:0]       cand_d;
    logic [NBTN-1:0][3:0]  cnt_q;
    logic [NBTN-1:0][3:0]  cnt_d;
    logic [NBTN-1:0]       level_q;
    logic [NBTN-1:0]       level_d;
    logic [NBTN-1:0]       press_q;
    logic [NBTN-1:0]       press_d;
    logic [NBTN-1:0]       release_q;
    logic [NBTN-1:0]       release_d;

    // Only the low NBTN data bits carry button levels; the rest are ignored.
    logic unused_dat_hi;
    assign unused_dat_hi = ^dat_i[31:NBTN];

    // Debounce next-state. A bit that differs from its candidate restarts the
    // run at 1; a matching bit extends the run, saturating at DEBOUNCE_CNT.
    // Reaching the threshold with a candidate that differs from the accepted
    // level commits the new level and raises the matching event. These
    // values are only committed in UPDATE.
    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < NBTN; i++) begin
            if (sample_q[i] != cand_q[i]) begin
                cand_d[i] = sample_q[i];
                cnt_d[i]  = 4'd1;
            end else if (cnt_q[i] < DB_MAX) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end
            if ((cnt_d[i] == DB_MAX) && (cand_d[i] != level_q[i])) begin
                level_d[i]   = cand_d[i];
                press_d[i]   = cand_d[i];
                release_d[i] = ~cand_d[i];
            end
        end
    end

    // Poll sequencer: IDLE counts the divider, BUS holds a single read until
    // ack or timeout (ack takes priority), UPDATE commits the debounce step.
    // All bus outputs and event pulses are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q     <= IDLE;
            div_q     <= '0;
            tmo_q     <= '0;
            adr_q     <= '0;
            sel_q     <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            err_q     <= '0;
            sample_q  <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= '0;
            release_q <= '0;
            case (fsm_q)
                IDLE: begin
                    if (poll_en) begin
                        if (div_q == DIV_LAST) begin
                            div_q <= '0;
                            tmo_q <= '0;
                            adr_q <= BTN_ADDR;
                            sel_q <= 2'b11;
                            cyc_q <= 1'b1;
                            stb_q <= 1'b1;
                            fsm_q <= BUS;
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
                end
                BUS: begin
                    if (ack_i) begin
                        sample_q <= dat_i[NBTN-1:0];
                        tmo_q    <= '0;
                        adr_q    <= '0;
                        sel_q    <= '0;
                        cyc_q    <= 1'b0;
                        stb_q    <= 1'b0;
                        fsm_q    <= UPDATE;
                    end else if (tmo_q == TMO_LAST) begin
                        tmo_q <= '0;
                        adr_q <= '0;
                        sel_q <= '0;
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        if (err_q != 8'hFF) begin
                            err_q <= err_q + 8'd1;
                        end
                        fsm_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                UPDATE: begin
                    cand_q    <= cand_d;
                    cnt_q     <= cnt_d;
                    level_q   <= level_d;
                    press_q   <= press_d;
                    release_q <= release_d;
                    fsm_q     <= IDLE;
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

`ifdef WB_BTN_POLL_IRQ_EN
    logic irq_q;

    // Sticky interrupt driven from the registered press pulse, so a clear
    // issued while btn_press is visible loses to the set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else if (|press_q) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq_o = irq_q;
`endif

    assign adr_o       = adr_q;
    assign dat_o       = '0;
    assign we_o        = 1'b0;
    assign sel_o       = sel_q;
    assign stb_o       = stb_q;
    assign cyc_o       = cyc_q;
    assign btn_state   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_wishbone_button_poller.sv
// ---------------------------------------------------------------------------
// Bench for wishbone_button_poller (POLL_DIV=8, DEBOUNCE_CNT=3,
// ACK_TIMEOUT=4, BTN_ADDR=32'h10). A behavioural responder serves reads from
// a stimulus queue; every served read is run through a run-length debounce
// model whose expected outputs are queued and compared when the DUT
// presents its post-update outputs.
// ---------------------------------------------------------------------------
module tb_wishbone_button_poller;

   localparam int NBTN        = 4;
   localparam int DB          = 3;
   localparam int WAIT_STATES = 1;

   typedef struct packed {
      logic [3:0] st;
      logic [3:0] pr;
      logic [3:0] rl;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] adr_o;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic        we_o;
   logic [1:0]  sel_o;
   logic        stb_o;
   logic        cyc_o;
   logic        ack_i;
   logic        poll_en;
   logic [3:0]  btn_state;
   logic [3:0]  btn_press;
   logic [3:0]  btn_release;
   logic [7:0]  err_cnt;
`ifdef WB_BTN_POLL_IRQ_EN
   logic        irq_o;
   logic        irq_clr;
`endif

   int errCount = 0;
   int checkCount = 0;

   logic [3:0] stimQ[$];
   exp_t       expQ[$];
   exp_t       monEntry;
   logic [3:0] holdVal = 4'b0000;
   bit         respEnable = 1'b1;
   int         waitCnt = 0;
   int         ackCount = 0;
   bit         ackIssued = 1'b0;
   bit         cmpStage = 1'b0;
   bit         pulseStage = 1'b0;

   logic [3:0] mdlLast = 4'b0000;
   logic [3:0] mdlState = 4'b0000;
   int         mdlRun[NBTN];

   wishbone_button_poller #(
      .BTN_ADDR    (32'h0000_0010),
      .NBTN        (NBTN),
      .POLL_DIV    (8),
      .DEBOUNCE_CNT(DB),
      .ACK_TIMEOUT (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .adr_o      (adr_o),
      .dat_o      (dat_o),
      .dat_i      (dat_i),
      .we_o       (we_o),
      .sel_o      (sel_o),
      .stb_o      (stb_o),
      .cyc_o      (cyc_o),
      .ack_i      (ack_i),
      .poll_en    (poll_en),
      .btn_state  (btn_state),
      .btn_press  (btn_press),
      .btn_release(btn_release),
`ifdef WB_BTN_POLL_IRQ_EN
      .irq_o      (irq_o),
      .irq_clr    (irq_clr),
`endif
      .err_cnt    (err_cnt)
   );

   // 100 MHz free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Queue button values for the responder to return on successive reads
   task automatic applyStimulus(input logic [3:0] val, input int reps);
      for (int r = 0; r < reps; r++) stimQ.push_back(val);
   endtask

   // Run-length debounce model: a bit is accepted once the same value has
   // been read DB times in a row and it differs from the accepted level
   task automatic modelRead(input logic [3:0] v);
      exp_t e;
      e.pr = '0;
      e.rl = '0;
      for (int i = 0; i < NBTN; i++) begin
         if (v[i] == mdlLast[i]) begin
            if (mdlRun[i] < 255) mdlRun[i]++;
         end else begin
            mdlLast[i] = v[i];
            mdlRun[i] = 1;
         end
         if (mdlRun[i] >= DB && mdlLast[i] != mdlState[i]) begin
            if (v[i]) e.pr[i] = 1'b1;
            else e.rl[i] = 1'b1;
            mdlState[i] = v[i];
         end
      end
      e.st = mdlState;
      expQ.push_back(e);
   endtask

   // Responder: drives ack/data on the falling edge after WAIT_STATES wait
   // cycles, and feeds every served value into the model
   always @(negedge clk) begin
      if (!rst) begin
         ack_i = 1'b0;
         waitCnt = 0;
      end else if (cyc_o && stb_o && respEnable && !ack_i) begin
         if (waitCnt == WAIT_STATES) begin
            if (stimQ.size() > 0) holdVal = stimQ.pop_front();
            dat_i = {28'($urandom), holdVal};
            ack_i = 1'b1;
            modelRead(holdVal);
            ackIssued = 1'b1;
            ackCount++;
         end else begin
            waitCnt++;
         end
      end else begin
         ack_i = 1'b0;
         waitCnt = 0;
      end
   end

   // Monitor: outputs settle one edge after the edge that samples ack; the
   // following cycle the event pulses must be gone again
   always @(posedge clk) begin
      #1;
      if (pulseStage) begin
         checkOutput("pressPulseClr", {28'd0, btn_press}, 32'd0);
         checkOutput("releasePulseClr", {28'd0, btn_release}, 32'd0);
         pulseStage = 1'b0;
      end
      if (cmpStage) begin
         checkOutput("sbAvail", {31'd0, expQ.size() != 0}, 32'd1);
         if (expQ.size() != 0) begin
            monEntry = expQ.pop_front();
            checkOutput("btnState", {28'd0, btn_state}, {28'd0, monEntry.st});
            checkOutput("btnPress", {28'd0, btn_press}, {28'd0, monEntry.pr});
            checkOutput("btnRelease", {28'd0, btn_release}, {28'd0, monEntry.rl});
         end
         cmpStage = 1'b0;
         pulseStage = 1'b1;
      end
      if (ackIssued) begin
         cmpStage = 1'b1;
         ackIssued = 1'b0;
      end
   end

   // Wait for n further acks (bounded), then let the monitor drain
   task automatic waitAcks(input int n);
      int target;
      int budget;
      target = ackCount + n;
      budget = 0;
      while (ackCount < target && budget < n * 40 + 40) begin
         @(posedge clk); #1;
         budget++;
      end
      checkOutput("ackWait", ackCount, target);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Wait for a cycle to start and measure how many cycles cyc_o stays high;
   // returns -1 when no cycle starts within the bound
   task automatic measureCycle(output int hi);
      int b;
      b = 0;
      hi = -1;
      while (!cyc_o && b < 40) begin
         @(posedge clk); #1;
         b++;
      end
      if (cyc_o) begin
         hi = 0;
         while (cyc_o && hi < 40) begin
            hi++;
            @(posedge clk); #1;
         end
      end
   endtask

`ifdef WB_BTN_POLL_IRQ_EN
   task automatic waitPress(output bit seen);
      int b;
      b = 0;
      seen = 1'b0;
      while (btn_press == 4'b0 && b < 300) begin
         @(posedge clk); #1;
         b++;
      end
      seen = (btn_press != 4'b0);
   endtask
`endif

   initial begin
      int hi;
      int edges;
      bit sawCyc;
`ifdef WB_BTN_POLL_IRQ_EN
      bit seen;
      irq_clr = 1'b0;
`endif
      for (int i = 0; i < NBTN; i++) mdlRun[i] = 0;
      rst = 1'b0;
      poll_en = 1'b1;
      dat_i = 32'd0;
      ack_i = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstCyc", {31'd0, cyc_o}, 32'd0);
      checkOutput("rstStb", {31'd0, stb_o}, 32'd0);
      checkOutput("rstAdr", adr_o, 32'd0);
      checkOutput("rstDat", dat_o, 32'd0);
      checkOutput("rstWe", {31'd0, we_o}, 32'd0);
      checkOutput("rstSel", {30'd0, sel_o}, 32'd0);
      checkOutput("rstState", {28'd0, btn_state}, 32'd0);
      checkOutput("rstPress", {28'd0, btn_press}, 32'd0);
      checkOutput("rstRelease", {28'd0, btn_release}, 32'd0);
      checkOutput("rstErr", {24'd0, err_cnt}, 32'd0);

      // First poll starts at cycle 8 and ends the cycle after ack
      @(negedge clk);
      rst = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      checkOutput("cycBeforeDiv", {31'd0, cyc_o}, 32'd0);
      @(posedge clk); #1;
      checkOutput("cycStart", {31'd0, cyc_o}, 32'd1);
      checkOutput("stbStart", {31'd0, stb_o}, 32'd1);
      checkOutput("adrStart", adr_o, 32'h10);
      checkOutput("weStart", {31'd0, we_o}, 32'd0);
      checkOutput("selStart", {30'd0, sel_o}, 32'd3);
      @(posedge clk); #1;
      checkOutput("cycWaitState", {31'd0, cyc_o}, 32'd1);
      checkOutput("adrWaitState", adr_o, 32'h10);
      @(posedge clk); #1;
      checkOutput("cycDropAfterAck", {31'd0, cyc_o}, 32'd0);
      checkOutput("stbDropAfterAck", {31'd0, stb_o}, 32'd0);
      checkOutput("firstAckCount", ackCount, 32'd1);
      repeat (3) @(posedge clk);
      #1;

      // Three consecutive presses of button 0
      applyStimulus(4'b0001, 3);
      waitAcks(3);

      // Release, then a glitch before three clean reads
      applyStimulus(4'b0000, 3);
      applyStimulus(4'b0001, 1);
      applyStimulus(4'b0000, 1);
      applyStimulus(4'b0001, 3);
      waitAcks(8);

      // Multi-bit: 0101 stable, then 0100 releases bit 0, then 1010 swaps
      applyStimulus(4'b0101, 3);
      applyStimulus(4'b0100, 3);
      applyStimulus(4'b1010, 3);
      waitAcks(9);
      checkOutput("stateAfterSwap", {28'd0, btn_state}, 32'h0000_000A);

      // Responder silent: each read times out after 4 cycles
      respEnable = 1'b0;
      measureCycle(hi);
      checkOutput("timeoutLen", hi, 32'd4);
      checkOutput("errAfterOne", {24'd0, err_cnt}, 32'd1);
      for (int n = 2; n <= 300; n++) begin
         measureCycle(hi);
         if (hi != 4) checkOutput("timeoutLenN", hi, 32'd4);
      end
      checkOutput("errSaturated", {24'd0, err_cnt}, 32'd255);
      checkOutput("stateKeptOnTimeout", {28'd0, btn_state}, {28'd0, mdlState});

      // poll_en low: no cycles; re-enabled: next cycle after 8 edges
      poll_en = 1'b0;
      sawCyc = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (cyc_o) sawCyc = 1'b1;
      end
      checkOutput("noPollWhenDisabled", {31'd0, sawCyc}, 32'd0);
      respEnable = 1'b1;
      poll_en = 1'b1;
      edges = 0;
      while (!cyc_o && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      checkOutput("divAfterEnable", edges, 32'd8);
      waitAcks(1);
      applyStimulus(4'b0110, 3);
      waitAcks(3);
      checkOutput("errHeld", {24'd0, err_cnt}, 32'd255);

`ifdef WB_BTN_POLL_IRQ_EN
      // Clear stale interrupt, press sets it, clear drops it, and a clear in
      // the press cycle loses to the set
      irq_clr = 1'b1;
      @(posedge clk); #1;
      irq_clr = 1'b0;
      checkOutput("irqCleared", {31'd0, irq_o}, 32'd0);
      applyStimulus(4'b0000, 3);
      applyStimulus(4'b0001, 3);
      waitPress(seen);
      checkOutput("irqPressSeen", {31'd0, seen}, 32'd1);
      @(posedge clk); #1;
      checkOutput("irqSet", {31'd0, irq_o}, 32'd1);
      irq_clr = 1'b1;
      @(posedge clk); #1;
      irq_clr = 1'b0;
      checkOutput("irqClr", {31'd0, irq_o}, 32'd0);
      applyStimulus(4'b0000, 3);
      applyStimulus(4'b0001, 3);
      waitPress(seen);
      checkOutput("irqPressSeen2", {31'd0, seen}, 32'd1);
      irq_clr = 1'b1;
      @(posedge clk); #1;
      irq_clr = 1'b0;
      checkOutput("irqSetWins", {31'd0, irq_o}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
`endif

      checkOutput("sbDrain", expQ.size(), 32'd0);

      // Asynchronous reset in the middle of a bus cycle
      measureCycle(hi);
      edges = 0;
      while (!cyc_o && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      checkOutput("cycBeforeAbort", {31'd0, cyc_o}, 32'd1);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("abortCyc", {31'd0, cyc_o}, 32'd0);
      checkOutput("abortStb", {31'd0, stb_o}, 32'd0);
      checkOutput("abortAdr", adr_o, 32'd0);
      checkOutput("abortState", {28'd0, btn_state}, 32'd0);
      checkOutput("abortErr", {24'd0, err_cnt}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
